// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings, MIPS opcode/funct constants and the decoded-control struct.
// Used by alu_ctrl_decode and alu_ctrl_issue (optional skid buffer: ALU_CTRL_SKID_EN).
package alu_ctrl_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   typedef struct packed {
      logic [2:0] signal;
      logic       invert_b;
      logic       cin;
      logic       b_sel_imm;
      logic       ext_zero;
      logic       illegal;
   } ctrl_t;

   // Subtract-type ops (signal[2]=1) invert B and inject a carry into slice 0.
   function automatic ctrl_t mk_ctrl(input logic [2:0] sig, input logic imm, input logic zx);
      ctrl_t c;
      c.signal    = sig;
      c.invert_b  = sig[2];
      c.cin       = sig[2];
      c.b_sel_imm = imm;
      c.ext_zero  = zx;
      c.illegal   = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of a MIPS instruction word into ALU control.
// Unsupported encodings produce an ADD-shaped control word with illegal set.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl
);

   logic unused_fields;
   assign unused_fields = ^instr[25:6];

   always_comb begin
      ctrl = '{signal: ALU_ADD, invert_b: 1'b0, cin: 1'b0,
               b_sel_imm: 1'b0, ext_zero: 1'b0, illegal: 1'b1};
      case (instr[31:26])
         OP_RTYPE: begin
            case (instr[5:0])
               FN_ADD, FN_ADDU: ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b0);
               FN_SUB, FN_SUBU: ctrl = mk_ctrl(ALU_SUB, 1'b0, 1'b0);
               FN_AND:          ctrl = mk_ctrl(ALU_AND, 1'b0, 1'b0);
               FN_OR:           ctrl = mk_ctrl(ALU_OR,  1'b0, 1'b0);
               FN_SLT:          ctrl = mk_ctrl(ALU_SLT, 1'b0, 1'b0);
               default:         ;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b0);
         OP_BEQ, OP_BNE:        ctrl = mk_ctrl(ALU_SUB, 1'b0, 1'b0);
         OP_SLTI:               ctrl = mk_ctrl(ALU_SLT, 1'b1, 1'b0);
         OP_ANDI:               ctrl = mk_ctrl(ALU_AND, 1'b1, 1'b1);
         OP_ORI:                ctrl = mk_ctrl(ALU_OR,  1'b1, 1'b1);
         default:               ;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ID->EX issue stage: decode, operand-B select and the ID/EX register with handshake.
// Define ALU_CTRL_SKID_EN for a registered in_ready with one extra skid entry.
module alu_ctrl_issue
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter bit ZEXT_LOGIC = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_rs_data,
   input  logic [DATA_W-1:0] in_rt_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        out_signal,
   output logic              out_invert_b,
   output logic              out_cin,
   output logic [DATA_W-1:0] out_op_a,
   output logic [DATA_W-1:0] out_op_b,
   output logic              out_illegal
);

   // Payload layout: {illegal, signal, invert_b, cin, op_a, op_b}.
   localparam int PW = 6 + 2 * DATA_W;

   ctrl_t             dec;
   logic [15:0]       imm16;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] op_b_sel;
   logic [PW-1:0]     in_pld;
   logic [PW-1:0]     out_pld;
   logic              in_fire;

   alu_ctrl_decode u_decode (
      .instr (in_instr),
      .ctrl  (dec)
   );

   assign imm16 = in_instr[15:0];

   always_comb begin
      imm_ext  = (dec.ext_zero && ZEXT_LOGIC) ? {{(DATA_W-16){1'b0}}, imm16}
                                              : {{(DATA_W-16){imm16[15]}}, imm16};
      op_b_sel = dec.b_sel_imm ? imm_ext : in_rt_data;
      if (dec.illegal)
         in_pld = {1'b1, ALU_ADD, 2'b00, {(2*DATA_W){1'b0}}};
      else
         in_pld = {1'b0, dec.signal, dec.invert_b, dec.cin, in_rs_data, op_b_sel};
   end

   // Handshake: a beat moves on a side exactly when valid & ready are both high at
   // the rising edge; the producer keeps its payload stable until that happens, and
   // flush or rst kill every held beat and block acceptance in that cycle.
   assign in_fire = in_valid & in_ready;

   assign {out_illegal, out_signal, out_invert_b, out_cin, out_op_a, out_op_b} = out_pld;

`ifdef ALU_CTRL_SKID_EN
   logic          skid_valid;
   logic          in_ready_q;
   logic [PW-1:0] skid_pld;

   assign in_ready = in_ready_q & ~flush & ~rst;

   // in_ready_q always mirrors !skid_valid, so a new beat can never overwrite the skid.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_pld    <= '0;
         skid_valid <= 1'b0;
         skid_pld   <= '0;
         in_ready_q <= 1'b1;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready_q <= 1'b1;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_pld    <= skid_pld;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
         end else if (in_fire) begin
            out_pld    <= in_pld;
            out_valid  <= 1'b1;
         end else begin
            out_valid  <= 1'b0;
         end
      end else if (in_fire) begin
         skid_pld   <= in_pld;
         skid_valid <= 1'b1;
         in_ready_q <= 1'b0;
      end
   end
`else
   assign in_ready = ~flush & ~rst & (~out_valid | out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_pld   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_fire) begin
         out_valid <= 1'b1;
         out_pld   <= in_pld;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule
